// File: rtl/cntr_multi_pkg.sv
// Shared types and logic-analyzer command field positions for the cntr_multi block.
package cntr_multi_pkg;

    typedef enum logic [1:0] {
        UP_WRAP   = 2'b00,
        DOWN_WRAP = 2'b01,
        UP_SAT    = 2'b10,
        BOUNCE    = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        LOAD    = 2'b00,
        MODE    = 2'b01,
        ENABLE  = 2'b10,
        DISABLE = 2'b11
    } opcode_e;

    localparam int LA_VAL_LSB  = 0;
    localparam int LA_VAL_W    = 20;
    localparam int LA_CH_LSB   = 20;
    localparam int LA_MODE_LSB = 22;
    localparam int LA_STB_BIT  = 24;
    localparam int LA_OP_LSB   = 25;
    localparam int LA_SEL_LSB  = 28;
    localparam int LA_DIV_LSB  = 30;
    localparam int LA_DIV_W    = 16;

endpackage

// File: rtl/cntr_multi_channel.sv
// One counter channel: wrap up/down, saturate or bounce, with load/mode/enable control
// and a one-cycle registered terminal-count pulse.
module cntr_channel
    import cntr_multi_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_tick,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_mode_wr,
    input  mode_e            i_mode,
    input  logic             i_en_set,
    input  logic             i_en_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_en,
    output logic             o_tc
);
    localparam logic [WIDTH-1:0] MAX_CNT = '1;
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    mode_e            r_mode;
    logic             r_dir_up;
    logic             r_en;
    logic             r_tc;

    logic [WIDTH-1:0] w_next;
    logic             w_dir_next;
    logic             w_tc_next;
    logic             w_go_up;

    always_comb begin
        w_next     = r_count;
        w_dir_next = r_dir_up;
        w_tc_next  = 1'b0;
        w_go_up    = 1'b1;
        case (r_mode)
            UP_WRAP: begin
                w_next    = r_count + ONE;
                w_tc_next = (r_count == MAX_CNT);
            end
            DOWN_WRAP: begin
                w_next    = r_count - ONE;
                w_tc_next = (r_count == '0);
            end
            UP_SAT: begin
                if (r_count != MAX_CNT) begin
                    w_next    = r_count + ONE;
                    w_tc_next = (r_count == (MAX_CNT - ONE));
                end
            end
            default: begin
                // A bounce counter parked at an end (e.g. just loaded) turns around first.
                w_go_up = r_dir_up ? (r_count != MAX_CNT) : (r_count == '0);
                w_next  = w_go_up ? (r_count + ONE) : (r_count - ONE);
                if (w_next == MAX_CNT) begin
                    w_tc_next  = 1'b1;
                    w_dir_next = 1'b0;
                end else if (w_next == '0) begin
                    w_tc_next  = 1'b1;
                    w_dir_next = 1'b1;
                end else begin
                    w_dir_next = w_go_up;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count  <= '0;
            r_mode   <= UP_WRAP;
            r_dir_up <= 1'b1;
            r_en     <= 1'b0;
            r_tc     <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (i_en_set) begin
                r_en <= 1'b1;
            end else if (i_en_clr) begin
                r_en <= 1'b0;
            end
            // LOAD and MODE take priority over a tick arriving in the same cycle.
            if (i_load) begin
                r_count  <= i_load_val;
                r_dir_up <= 1'b1;
            end else if (i_mode_wr) begin
                r_mode   <= i_mode;
                r_dir_up <= 1'b1;
            end else if (i_tick && r_en) begin
                r_count  <= w_next;
                r_dir_up <= w_dir_next;
                r_tc     <= w_tc_next;
            end
        end
    end

    assign o_count = r_count;
    assign o_en    = r_en;
    assign o_tc    = r_tc;

endmodule

// File: rtl/cntr_multi.sv
// Multi-channel counter block driven by logic-analyzer commands; count and enables on io_out.
// Optional shared tick prescaler enabled by defining CNTR_PRESCALE_EN.
module cntr_multi
    import cntr_multi_pkg::*;
#(
    parameter int WIDTH = 20,
    parameter int N_CH  = 4,
    parameter int IO_W  = 38
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_ni,
    input  logic [63:0]     la_data_in,
    input  logic [63:0]     la_oenb,
    output logic [IO_W-1:0] io_out,
    output logic [IO_W-1:0] io_oeb,
    output logic [2:0]      user_irq
);
    localparam logic [2:0] NCH_L = 3'(N_CH);

    logic [63:0]      w_la;
    logic             w_fire;
    logic [1:0]       w_ch;
    logic             w_ch_ok;
    opcode_e          w_op;
    mode_e            w_mode;
    logic [29:0]      w_val_ext;
    logic [WIDTH-1:0] w_load_val;
    logic [1:0]       w_sel;
    logic             w_tick;
    logic [WIDTH-1:0] w_cnt [N_CH];
    logic [N_CH-1:0]  w_en;
    logic [N_CH-1:0]  w_tc;
    logic [WIDTH-1:0] w_sel_cnt;
    logic [IO_W-1:0]  w_io_next;

    logic             r_strobe_q;
    logic [1:0]       r_sel;
    logic [IO_W-1:0]  r_io_out;

    // Undriven LA bits (oenb high) read as zero.
    assign w_la       = la_data_in & ~la_oenb;
    assign w_fire     = w_la[LA_STB_BIT] & ~r_strobe_q;
    assign w_ch       = w_la[LA_CH_LSB +: 2];
    assign w_ch_ok    = ({1'b0, w_ch} < NCH_L);
    assign w_op       = opcode_e'(w_la[LA_OP_LSB +: 2]);
    assign w_mode     = mode_e'(w_la[LA_MODE_LSB +: 2]);
    assign w_val_ext  = {10'b0, w_la[LA_VAL_LSB +: LA_VAL_W]};
    assign w_load_val = w_val_ext[WIDTH-1:0];
    assign w_sel      = w_la[LA_SEL_LSB +: 2];

`ifdef CNTR_PRESCALE_EN
    logic [15:0] w_div;
    logic [15:0] r_div_q;
    logic [15:0] r_presc;

    assign w_div  = w_la[LA_DIV_LSB +: LA_DIV_W];
    assign w_tick = (r_presc == r_div_q);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_div_q <= '0;
            r_presc <= '0;
        end else if (w_div != r_div_q) begin
            r_div_q <= w_div;
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 16'd1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic w_hit;
        assign w_hit = w_fire && w_ch_ok && (w_ch == 2'(g));

        cntr_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .i_clk      (wb_clk_i),
            .i_rst_n    (wb_rst_ni),
            .i_tick     (w_tick),
            .i_load     (w_hit && (w_op == LOAD)),
            .i_load_val (w_load_val),
            .i_mode_wr  (w_hit && (w_op == MODE)),
            .i_mode     (w_mode),
            .i_en_set   (w_hit && (w_op == ENABLE)),
            .i_en_clr   (w_hit && (w_op == DISABLE)),
            .o_count    (w_cnt[g]),
            .o_en       (w_en[g]),
            .o_tc       (w_tc[g])
        );
    end

    always_comb begin
        w_sel_cnt = w_cnt[0];
        for (int i = 0; i < N_CH; i++) begin
            if (r_sel == 2'(i)) begin
                w_sel_cnt = w_cnt[i];
            end
        end
    end

    always_comb begin
        w_io_next                 = '0;
        w_io_next[WIDTH-1:0]      = w_sel_cnt;
        w_io_next[WIDTH +: N_CH]  = w_en;
    end

    // Strobe history resets high so a strobe held through reset cannot fire.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_strobe_q <= 1'b1;
            r_sel      <= 2'b00;
            r_io_out   <= '0;
        end else begin
            r_strobe_q <= w_la[LA_STB_BIT];
            r_sel      <= ({1'b0, w_sel} < NCH_L) ? w_sel : 2'b00;
            r_io_out   <= w_io_next;
        end
    end

    assign io_out   = r_io_out;
    assign io_oeb   = '0;
    assign user_irq = {1'b0, w_tc[0], |w_tc};

endmodule

// File: tb/tb_cntr_multi.sv
// Scoreboard bench for cntr_multi (WIDTH=20, N_CH=3): a behavioural model queues expected outputs per edge.
module tb_cntr_multi;
  localparam int W   = 20;
  localparam int NC  = 3;
  localparam int IOW = 38;
  localparam logic [W-1:0] MAXV = '1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [63:0]    la_data_in;
  logic [63:0]    la_oenb;
  logic [IOW-1:0] io_out;
  logic [IOW-1:0] io_oeb;
  logic [2:0]     user_irq;

  int n_total = 0;
  int n_bad   = 0;

  logic [1:0]  sel_v = 2'd0;
  logic [15:0] div_v = 16'd0;
  int          p0, p1;

  cntr_multi #(.WIDTH(W), .N_CH(NC), .IO_W(IOW)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .user_irq   (user_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference model
  logic [W-1:0]   m_cnt  [NC];
  logic [1:0]     m_mode [NC];
  logic           m_dir  [NC];
  logic           m_en   [NC];
  logic           m_tc   [NC];
  logic           m_stq, m_tk, m_fire, m_any;
  logic [1:0]     m_sel;
  logic [IOW-1:0] m_out;
  logic [15:0]    m_div, m_ps;
  logic [63:0]    m_la;
  logic [IOW+2:0] exp_q[$];
  logic [IOW+2:0] mon_e;

  task automatic step_ch(input int c);
    case (m_mode[c])
      2'b00: begin
        m_cnt[c] = (m_cnt[c] == MAXV) ? '0 : m_cnt[c] + 1'b1;
        m_tc[c]  = (m_cnt[c] == '0);
      end
      2'b01: begin
        m_cnt[c] = (m_cnt[c] == '0) ? MAXV : m_cnt[c] - 1'b1;
        m_tc[c]  = (m_cnt[c] == MAXV);
      end
      2'b10: begin
        if (m_cnt[c] != MAXV) begin
          m_cnt[c] = m_cnt[c] + 1'b1;
          m_tc[c]  = (m_cnt[c] == MAXV);
        end
      end
      default: begin
        if (m_dir[c]) begin
          if (m_cnt[c] == MAXV) begin m_cnt[c] = MAXV - 1'b1; m_dir[c] = 1'b0; end
          else m_cnt[c] = m_cnt[c] + 1'b1;
        end else begin
          if (m_cnt[c] == '0) begin m_cnt[c] = 20'd1; m_dir[c] = 1'b1; end
          else m_cnt[c] = m_cnt[c] - 1'b1;
        end
        if (m_cnt[c] == MAXV) begin m_tc[c] = 1'b1; m_dir[c] = 1'b0; end
        if (m_cnt[c] == '0)   begin m_tc[c] = 1'b1; m_dir[c] = 1'b1; end
      end
    endcase
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NC; c++) begin
        m_cnt[c] = '0; m_mode[c] = 2'b00; m_dir[c] = 1'b1; m_en[c] = 1'b0; m_tc[c] = 1'b0;
      end
      m_stq = 1'b1; m_sel = 2'd0; m_out = '0; m_div = '0; m_ps = '0;
      exp_q.delete();
    end else begin
      m_la = la_data_in & ~la_oenb;
      m_out = '0;
      m_out[W-1:0] = m_cnt[m_sel];
      for (int c = 0; c < NC; c++) m_out[W+c] = m_en[c];
`ifdef CNTR_PRESCALE_EN
      m_tk = (m_ps == m_div);
      if (m_la[45:30] != m_div) begin m_div = m_la[45:30]; m_ps = '0; end
      else if (m_tk) m_ps = '0;
      else m_ps = m_ps + 16'd1;
`else
      m_tk = 1'b1;
`endif
      m_fire = m_la[24] && !m_stq;
      m_any  = 1'b0;
      for (int c = 0; c < NC; c++) begin
        m_tc[c] = 1'b0;
        if (m_fire && m_la[21:20] == 2'(c) && m_la[26:25] == 2'b00) begin
          m_cnt[c] = m_la[19:0]; m_dir[c] = 1'b1;
        end else if (m_fire && m_la[21:20] == 2'(c) && m_la[26:25] == 2'b01) begin
          m_mode[c] = m_la[23:22]; m_dir[c] = 1'b1;
        end else if (m_tk && m_en[c]) begin
          step_ch(c);
        end
        if (m_fire && m_la[21:20] == 2'(c) && m_la[26:25] == 2'b10) m_en[c] = 1'b1;
        if (m_fire && m_la[21:20] == 2'(c) && m_la[26:25] == 2'b11) m_en[c] = 1'b0;
        m_any = m_any | m_tc[c];
      end
      m_stq = m_la[24];
      m_sel = (m_la[29:28] < 2'(NC)) ? m_la[29:28] : 2'd0;
      exp_q.push_back({1'b0, m_tc[0], m_any, m_out});
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("io_out", 64'(io_out), 64'(mon_e[IOW-1:0]));
      chk("user_irq", 64'(user_irq), 64'(mon_e[IOW+2:IOW]));
    end
  end

  task automatic set_la(input logic stb, input logic [1:0] op, input logic [1:0] ch,
                        input logic [1:0] md, input logic [19:0] val);
    la_data_in        = '0;
    la_data_in[19:0]  = val;
    la_data_in[21:20] = ch;
    la_data_in[23:22] = md;
    la_data_in[24]    = stb;
    la_data_in[26:25] = op;
    la_data_in[29:28] = sel_v;
    la_data_in[45:30] = div_v;
  endtask

  task automatic cmd(input logic [1:0] op, input logic [1:0] ch, input logic [1:0] md,
                     input logic [19:0] val);
    @(negedge clk); set_la(1'b1, op, ch, md, val);
    @(negedge clk); set_la(1'b0, op, ch, md, val);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic count_irq(input int n, output int c0, output int c1);
    c0 = 0; c1 = 0;
    repeat (n) begin
      @(negedge clk);
      c0 += int'(user_irq[0]);
      c1 += int'(user_irq[1]);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    la_oenb = '0;
    set_la(1'b1, 2'b00, 2'd0, 2'b00, 20'd77);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_io_out", 64'(io_out), 64'd0);
    chk("rst_irq", 64'(user_irq), 64'd0);
    chk("io_oeb", 64'(io_oeb), 64'd0);
    rst_n = 1'b1;
    cyc(3);
    set_la(1'b0, 2'b00, 2'd0, 2'b00, 20'd77);
    cyc(3);
    chk("held_strobe", 64'(io_out), 64'd0);

    // ch0 counts up from 5
    sel_v = 2'd0;
    cmd(2'b00, 2'd0, 2'b00, 20'd5);
    cmd(2'b10, 2'd0, 2'b00, 20'd0);
    cyc(6);
    chk("ch0_en_flag", 64'(io_out[W+2:W]), 64'b001);

    // ch1 wraps FFFFE -> FFFFF -> 0
    sel_v = 2'd1;
    cmd(2'b00, 2'd1, 2'b00, 20'hFFFFE);
    cmd(2'b01, 2'd1, 2'b00, 20'd0);
    cmd(2'b10, 2'd1, 2'b00, 20'd0);
    count_irq(8, p0, p1);
    chk("wrap_irq0_pulses", 64'(p0), 64'd1);
    chk("wrap_irq1_pulses", 64'(p1), 64'd0);

    // ch2 saturates at max, then bounces
    sel_v = 2'd2;
    cmd(2'b00, 2'd2, 2'b00, 20'hFFFFD);
    cmd(2'b01, 2'd2, 2'b10, 20'd0);
    cmd(2'b10, 2'd2, 2'b00, 20'd0);
    count_irq(10, p0, p1);
    chk("sat_irq0_pulses", 64'(p0), 64'd1);
    chk("sat_hold", 64'(io_out[W-1:0]), 64'hFFFFF);
    cmd(2'b01, 2'd2, 2'b11, 20'd0);
    cmd(2'b00, 2'd2, 2'b00, 20'hFFFFE);
    count_irq(6, p0, p1);
    chk("bounce_irq0_pulses", 64'(p0), 64'd1);

    // LOAD on a ticking channel wins, then DISABLE (tick still taken that edge)
    sel_v = 2'd0;
    cmd(2'b00, 2'd0, 2'b00, 20'h123);
    cmd(2'b11, 2'd0, 2'b00, 20'd0);
    cyc(3);
    chk("load_then_disable", 64'(io_out[W-1:0]), 64'h125);
    chk("ch0_disabled", 64'(io_out[W]), 64'd0);

    // Out-of-range channel and masked strobe are ignored; sel 3 falls back to ch0
    sel_v = 2'd3;
    cmd(2'b00, 2'd3, 2'b00, 20'h55);
    la_oenb[24] = 1'b1;
    cmd(2'b00, 2'd0, 2'b00, 20'h77);
    la_oenb = '0;
    cyc(3);
    chk("ignored_cmds", 64'(io_out[W-1:0]), 64'h125);

    // Prescaler divisor 3 (only effective when the prescaler is built in)
    sel_v = 2'd0;
    div_v = 16'd3;
    cmd(2'b00, 2'd0, 2'b00, 20'h10);
    cmd(2'b10, 2'd0, 2'b00, 20'd0);
    cyc(16);
    div_v = 16'd0;
    set_la(1'b0, 2'b00, 2'd0, 2'b00, 20'd0);
    cyc(4);

    // Mid-count reset: everything clears and stays idle until re-enabled
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_io_out", 64'(io_out), 64'd0);
    chk("midrst_irq", 64'(user_irq), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(5);
    chk("after_rst_idle", 64'(io_out), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
